// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter for the shared cache refill/writeback bus. One requester owns the
// bus for a whole burst: address phase, every data beat and (for writes) the response.
module cache_bus_arbiter #(
  parameter int N_MASTER = 2,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTER-1:0]        m_req_valid_i,
  output logic [N_MASTER-1:0]        m_req_ready_o,
  input  logic [N_MASTER*32-1:0]     m_req_addr_i,
  input  logic [N_MASTER-1:0]        m_req_write_i,
  input  logic [N_MASTER*LEN_W-1:0]  m_req_len_i,
  input  logic [N_MASTER*DATA_W-1:0] m_wdata_i,
  input  logic [N_MASTER-1:0]        m_wdata_valid_i,
  output logic [N_MASTER-1:0]        m_wdata_ready_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic [N_MASTER-1:0]        m_rdata_valid_o,
  output logic                       m_rdata_last_o,
  output logic [N_MASTER-1:0]        m_wresp_valid_o,
  output logic                       s_req_valid_o,
  input  logic                       s_req_ready_i,
  output logic [31:0]                s_req_addr_o,
  output logic                       s_req_write_o,
  output logic [LEN_W-1:0]           s_req_len_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  output logic                       s_wdata_valid_o,
  output logic                       s_wdata_last_o,
  input  logic                       s_wdata_ready_i,
  input  logic [DATA_W-1:0]          s_rdata_i,
  input  logic                       s_rdata_valid_i,
  input  logic                       s_rdata_last_i,
  input  logic                       s_wresp_valid_i,
  output logic [N_MASTER-1:0]        grant_o,
  output logic                       bus_busy_o
);

  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, WRESP} state_t;

  state_t              state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;
  logic [IDX_W-1:0]    gidx_inc;
  logic                sel_req_valid;
  logic [31:0]         sel_addr;
  logic                sel_write;
  logic [LEN_W-1:0]    sel_len;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_wvalid;

  // Scan downwards so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    pick_idx = ptr_q;
    pick_vld = 1'b0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      cand_idx = IDX_W'(cand);
      if (m_req_valid_i[cand_idx]) begin
        pick_idx = cand_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign gidx_inc      = (int'(gidx_q) == N_MASTER - 1) ? '0 : gidx_q + 1'b1;
  assign sel_req_valid = m_req_valid_i[gidx_q];
  assign sel_addr      = m_req_addr_i[int'(gidx_q)*32 +: 32];
  assign sel_write     = m_req_write_i[gidx_q];
  assign sel_len       = m_req_len_i[int'(gidx_q)*LEN_W +: LEN_W];
  assign sel_wdata     = m_wdata_i[int'(gidx_q)*DATA_W +: DATA_W];
  assign sel_wvalid    = m_wdata_valid_i[gidx_q];

  assign m_rdata_o  = s_rdata_i;
  assign grant_o    = grant_q;
  assign bus_busy_o = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready/valid toward a master is only ever driven on the bit of the current owner.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    gidx_d          = gidx_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    m_req_ready_o   = '0;
    m_wdata_ready_o = '0;
    m_rdata_valid_o = '0;
    m_rdata_last_o  = 1'b0;
    m_wresp_valid_o = '0;
    s_req_valid_o   = 1'b0;
    s_req_addr_o    = '0;
    s_req_write_o   = 1'b0;
    s_req_len_o     = '0;
    s_wdata_o       = '0;
    s_wdata_valid_o = 1'b0;
    s_wdata_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d           = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          state_d          = ADDR;
        end
      end
      ADDR: begin
        s_req_valid_o         = 1'b1;
        s_req_addr_o          = sel_addr;
        s_req_write_o         = sel_write;
        s_req_len_o           = sel_len;
        m_req_ready_o[gidx_q] = s_req_ready_i;
        if (s_req_ready_i) begin
          cnt_d   = sel_len;
          state_d = sel_write ? WDATA : RDATA;
        end
      end
      WDATA: begin
        s_wdata_o               = sel_wdata;
        s_wdata_valid_o         = sel_wvalid;
        s_wdata_last_o          = (cnt_q == '0);
        m_wdata_ready_o[gidx_q] = s_wdata_ready_i;
        if (sel_wvalid && s_wdata_ready_i) begin
          if (cnt_q == '0) state_d = WRESP;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      RDATA: begin
        m_rdata_valid_o[gidx_q] = s_rdata_valid_i;
        m_rdata_last_o          = s_rdata_last_i;
        // The bridge's last flag ends the burst; the beat counter is not consulted here.
        if (s_rdata_valid_i && s_rdata_last_i) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_inc;
        end
      end
      WRESP: begin
        m_wresp_valid_o[gidx_q] = s_wresp_valid_i;
        if (s_wresp_valid_i) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A requester may not withdraw a request while its address phase is on the bus.
  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == ADDR) |-> sel_req_valid);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed scenarios plus random traffic from two masters
// against a bus-slave responder, checked by a round-robin transaction model.
module tb_cache_bus_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]    m_req_valid_i, m_req_ready_o, m_req_write_i;
  logic [N*32-1:0] m_req_addr_i;
  logic [N*LW-1:0] m_req_len_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N-1:0]    m_wdata_valid_i, m_wdata_ready_o, m_rdata_valid_o, m_wresp_valid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            m_rdata_last_o;
  logic            s_req_valid_o, s_req_ready_i, s_req_write_o;
  logic [31:0]     s_req_addr_o;
  logic [LW-1:0]   s_req_len_o;
  logic [DW-1:0]   s_wdata_o, s_rdata_i;
  logic            s_wdata_valid_o, s_wdata_last_o, s_wdata_ready_i;
  logic            s_rdata_valid_i, s_rdata_last_i, s_wresp_valid_i;
  logic [N-1:0]    grant_o;
  logic            bus_busy_o;

  cache_bus_arbiter #(.N_MASTER(N), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
    .m_req_addr_i(m_req_addr_i), .m_req_write_i(m_req_write_i), .m_req_len_i(m_req_len_i),
    .m_wdata_i(m_wdata_i), .m_wdata_valid_i(m_wdata_valid_i), .m_wdata_ready_o(m_wdata_ready_o),
    .m_rdata_o(m_rdata_o), .m_rdata_valid_o(m_rdata_valid_o), .m_rdata_last_o(m_rdata_last_o),
    .m_wresp_valid_o(m_wresp_valid_o),
    .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i), .s_req_addr_o(s_req_addr_o),
    .s_req_write_o(s_req_write_o), .s_req_len_o(s_req_len_o),
    .s_wdata_o(s_wdata_o), .s_wdata_valid_o(s_wdata_valid_o), .s_wdata_last_o(s_wdata_last_o),
    .s_wdata_ready_i(s_wdata_ready_i),
    .s_rdata_i(s_rdata_i), .s_rdata_valid_i(s_rdata_valid_i), .s_rdata_last_i(s_rdata_last_i),
    .s_wresp_valid_i(s_wresp_valid_i),
    .grant_o(grant_o), .bus_busy_o(bus_busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int stall_req = 0;

  // Expected beats: {last, data}
  logic [DW:0] exp_w_q[$];
  logic [DW:0] exp_r_q[$];

  logic [31:0]   pend_addr [N];
  logic          pend_wr   [N];
  logic [LW-1:0] pend_len  [N];
  logic [DW-1:0] pend_wdata [N][16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int m);
    checks++;
    failures++;
    $display("FAIL %s: master %0d got no response, expected one within the cycle budget at %0t",
             name, m, $time);
  endtask

  // ---------------- master driver tasks ----------------
  task automatic req_phase(input int m, input logic [31:0] addr, input logic wr,
                           input logic [LW-1:0] len, output bit ok, output int cyc);
    @(posedge clk); #1;
    pend_addr[m] = addr;
    pend_wr[m]   = wr;
    pend_len[m]  = len;
    for (int b = 0; b < 16; b++) pend_wdata[m][b] = $urandom();
    m_req_valid_i[m]           = 1'b1;
    m_req_addr_i[m*32 +: 32]   = addr;
    m_req_write_i[m]           = wr;
    m_req_len_i[m*LW +: LW]    = len;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (m_req_ready_o[m]) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    if (!ok) timeout_fail("req_ready_timeout", m);
    else if (wr)
      for (int b = 0; b <= int'(len); b++) exp_w_q.push_back({(b == int'(len)), pend_wdata[m][b]});
    @(posedge clk); #1;
    m_req_valid_i[m] = 1'b0;
  endtask

  task automatic wbeat(input int m, input int b, output bit ok);
    int gap;
    int budget;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
    m_wdata_valid_i[m]     = 1'b1;
    m_wdata_i[m*DW +: DW]  = pend_wdata[m][b];
    ok = 1'b0;
    budget = 0;
    while (budget < 200) begin
      @(negedge clk);
      if (m_wdata_ready_o[m]) begin
        ok = 1'b1;
        break;
      end
      budget++;
    end
    if (!ok) timeout_fail("wdata_ready_timeout", m);
    @(posedge clk); #1;
    m_wdata_valid_i[m] = 1'b0;
  endtask

  task automatic wait_done(input int m, input logic wr);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (wr ? m_wresp_valid_o[m] : (m_rdata_valid_o[m] && m_rdata_last_o)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeout_fail(wr ? "wresp_timeout" : "rlast_timeout", m);
    @(posedge clk); #1;
  endtask

  task automatic master_txn(input int m, input logic [31:0] addr, input logic wr,
                            input logic [LW-1:0] len);
    bit ok;
    int cyc;
    req_phase(m, addr, wr, len, ok, cyc);
    if (!ok) return;
    if (wr)
      for (int b = 0; b <= int'(len); b++) begin
        wbeat(m, b, ok);
        if (!ok) return;
      end
    wait_done(m, wr);
  endtask

  task automatic random_master(input int m, input int n_txn);
    for (int t = 0; t < n_txn; t++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      master_txn(m, $urandom(), 1'($urandom_range(0, 1)), LW'($urandom_range(0, 7)));
    end
  endtask

  // ---------------- bus-side responder ----------------
  initial begin
    int sl_ph, sl_len, sl_beats, sl_dly;
    logic n_rr, n_wr, n_rv, n_rl, n_wb;
    logic [DW-1:0] n_rd;
    sl_ph = 0; sl_len = 0; sl_beats = 0; sl_dly = 0;
    s_req_ready_i = 1'b0; s_wdata_ready_i = 1'b0; s_rdata_valid_i = 1'b0;
    s_rdata_last_i = 1'b0; s_wresp_valid_i = 1'b0; s_rdata_i = '0;
    forever begin
      @(negedge clk);
      n_rr = 1'b0; n_wr = 1'b0; n_rv = 1'b0; n_rl = 1'b0; n_wb = 1'b0;
      n_rd = $urandom();
      if (rst) begin
        sl_ph = 0;
      end else begin
        case (sl_ph)
          0: if (s_req_valid_o && s_req_ready_i) begin
               sl_len = int'(s_req_len_o);
               sl_beats = 0;
               sl_ph = s_req_write_o ? 1 : 3;
             end
          1: if (s_wdata_valid_o && s_wdata_ready_i) begin
               sl_beats++;
               if (sl_beats > sl_len) begin
                 sl_ph = 2;
                 sl_dly = $urandom_range(0, 2);
               end
             end
          2: if (s_wresp_valid_i) sl_ph = 0;
          3: if (s_rdata_valid_i && s_rdata_last_i) sl_ph = 0;
          default: sl_ph = 0;
        endcase
        case (sl_ph)
          0: if (s_req_valid_o) begin
               if (stall_req > 0) stall_req--;
               else n_rr = 1'($urandom_range(0, 1));
             end
          1: n_wr = ($urandom_range(0, 3) != 0);
          2: if (sl_dly == 0) n_wb = 1'b1; else sl_dly--;
          3: if (sl_beats <= sl_len && $urandom_range(0, 3) != 0) begin
               n_rv = 1'b1;
               n_rl = (sl_beats == sl_len);
               sl_beats++;
               exp_r_q.push_back({n_rl, n_rd});
             end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      s_req_ready_i   = n_rr;
      s_wdata_ready_i = n_wr;
      s_rdata_valid_i = n_rv;
      s_rdata_last_i  = n_rl;
      s_rdata_i       = n_rd;
      s_wresp_valid_i = n_wb;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // Transaction-level model: phase 0 = bus free, 1 = address, 2 = write beats,
  // 3 = awaiting write response, 4 = read beats.
  initial begin
    int ph, owner, rr_ptr;
    logic [N-1:0] oh;
    logic [DW:0]  e;
    ph = 0; owner = 0; rr_ptr = 0;
    forever begin
      @(negedge clk);
      oh = '0;
      oh[owner] = 1'b1;
      if (rst) begin
        check("reset_grant", 64'(grant_o), 64'd0);
        check("reset_busy", 64'(bus_busy_o), 64'd0);
        check("reset_outs", 64'({m_req_ready_o, m_wdata_ready_o, m_rdata_valid_o, m_wresp_valid_o,
              m_rdata_last_o, s_req_valid_o, s_wdata_valid_o, s_wdata_last_o}), 64'd0);
        ph = 0; rr_ptr = 0;
        exp_w_q.delete();
        exp_r_q.delete();
      end else if (ph == 0) begin
        check("idle_grant", 64'(grant_o), 64'd0);
        check("idle_busy", 64'(bus_busy_o), 64'd0);
        check("idle_outs", 64'({m_req_ready_o, m_wdata_ready_o, m_rdata_valid_o, m_wresp_valid_o,
              m_rdata_last_o, s_req_valid_o, s_wdata_valid_o, s_wdata_last_o}), 64'd0);
        if (|m_req_valid_i) begin
          for (int k = N - 1; k >= 0; k--)
            if (m_req_valid_i[(rr_ptr + k) % N]) owner = (rr_ptr + k) % N;
          ph = 1;
        end
      end else begin
        check("grant", 64'(grant_o), 64'(oh));
        check("busy", 64'(bus_busy_o), 64'd1);
        check("req_ready", 64'(m_req_ready_o), 64'((ph == 1 && s_req_ready_i) ? oh : '0));
        check("wdata_ready", 64'(m_wdata_ready_o), 64'((ph == 2 && s_wdata_ready_i) ? oh : '0));
        check("rdata_valid", 64'(m_rdata_valid_o), 64'((ph == 4 && s_rdata_valid_i) ? oh : '0));
        check("wresp_valid", 64'(m_wresp_valid_o), 64'((ph == 3 && s_wresp_valid_i) ? oh : '0));
        case (ph)
          1: begin
            check("s_req_valid", 64'(s_req_valid_o), 64'd1);
            check("s_req_addr", 64'(s_req_addr_o), 64'(pend_addr[owner]));
            check("s_req_write", 64'(s_req_write_o), 64'(pend_wr[owner]));
            check("s_req_len", 64'(s_req_len_o), 64'(pend_len[owner]));
            if (s_req_ready_i) ph = pend_wr[owner] ? 2 : 4;
          end
          2: begin
            check("s_wdata_valid", 64'(s_wdata_valid_o), 64'(m_wdata_valid_i[owner]));
            if (s_wdata_valid_o && s_wdata_ready_i) begin
              if (exp_w_q.size() == 0) check("wbeat_unexpected", 64'd1, 64'd0);
              else begin
                e = exp_w_q.pop_front();
                check("s_wdata", 64'(s_wdata_o), 64'(e[DW-1:0]));
                check("s_wdata_last", 64'(s_wdata_last_o), 64'(e[DW]));
                if (e[DW]) ph = 3;
              end
            end
          end
          3: if (s_wresp_valid_i) begin
            rr_ptr = (owner + 1) % N;
            ph = 0;
          end
          4: if (s_rdata_valid_i) begin
            if (exp_r_q.size() == 0) check("rbeat_unexpected", 64'd1, 64'd0);
            else begin
              e = exp_r_q.pop_front();
              check("m_rdata", 64'(m_rdata_o), 64'(e[DW-1:0]));
              check("m_rdata_last", 64'(m_rdata_last_o), 64'(e[DW]));
              if (e[DW]) begin
                rr_ptr = (owner + 1) % N;
                ph = 0;
              end
            end
          end
          default: ph = 0;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int cyc;
    m_req_valid_i = '0; m_req_addr_i = '0; m_req_write_i = '0; m_req_len_i = '0;
    m_wdata_i = '0; m_wdata_valid_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous requests with pointer at 0: m0 read then m1 write, then m0 again.
    fork
      master_txn(0, 32'h1c00_0000, 1'b0, LW'(3));
      master_txn(1, 32'h2000_0040, 1'b1, LW'(1));
    join
    master_txn(0, 32'h1c00_0100, 1'b0, LW'(3));

    // m1 arrives while m0 is mid-burst and must wait for it to finish.
    fork
      master_txn(0, 32'h1c00_0200, 1'b0, LW'(7));
      begin
        repeat (4) @(posedge clk);
        master_txn(1, 32'h3000_0000, 1'b0, LW'(0));
      end
    join

    // Address phase stalled by the bridge.
    stall_req = 5;
    req_phase(1, 32'hdead_bee0, 1'b0, LW'(2), ok, cyc);
    check("addr_stall_wait_ge7", 64'(cyc >= 7), 64'd1);
    if (ok) wait_done(1, 1'b0);

    // m0 completes so the pointer moves to 1, then m1 writes and is reset after one beat.
    master_txn(0, 32'h1c00_0300, 1'b0, LW'(1));
    req_phase(1, 32'h4000_0000, 1'b1, LW'(3), ok, cyc);
    if (ok) wbeat(1, 0, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    m_req_valid_i = '0;
    m_wdata_valid_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pointer restarts at 0, so m0 must win this tie.
    fork
      master_txn(1, 32'h5000_0000, 1'b0, LW'(1));
      master_txn(0, 32'h5100_0000, 1'b0, LW'(1));
    join

    fork
      random_master(0, 12);
      random_master(1, 12);
    join

    repeat (6) @(posedge clk);
    check("exp_w_q_drained", 64'(exp_w_q.size()), 64'd0);
    check("exp_r_q_drained", 64'(exp_r_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
